// File: rtl/stacker_game_ctrl_pkg.sv
// Shared types and constants for the four-row stacker game controller.
package stacker_game_ctrl_pkg;

  localparam int unsigned NUM_ROWS      = 4;
  localparam int unsigned DEF_POS_W     = 3;
  localparam int unsigned DEF_SCORE_W   = 8;
  localparam int unsigned DEF_MAX_LEVEL = 7;
  localparam int unsigned STATE_W       = 3;
  localparam int unsigned ROW_IDX_W     = 2;
  localparam int unsigned SPEED_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    CHECK    = 3'd2,
    LEVEL_UP = 3'd3,
    OVER     = 3'd4
  } state_e;

  // One-hot row mask for a row index.
  function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_IDX_W-1:0] idx);
    return NUM_ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/stacker_game_ctrl_key_press_sync.sv
// Active-low key synchronizer with a registered one-cycle press pulse on the falling edge.
module key_press_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [2:0] valid;

  // valid marks which stages hold real post-reset samples, so a key held
  // through reset release never produces a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      valid <= 3'b000;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
      valid <= {valid[1:0], 1'b1};
      press <= valid[2] & prev & ~sync2;
    end
  end

endmodule

// File: rtl/stacker_game_ctrl.sv
// Stacker game sequencer: Stop button handling, row run/lit control, level, score and speed.
module stacker_game_ctrl
  import stacker_game_ctrl_pkg::*;
#(
  parameter int unsigned POS_W     = DEF_POS_W,
  parameter int unsigned SCORE_W   = DEF_SCORE_W,
  parameter int unsigned MAX_LEVEL = DEF_MAX_LEVEL
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      Stop,
  input  logic [NUM_ROWS*POS_W-1:0] row_pos,
  output logic [NUM_ROWS-1:0]       row_run,
  output logic [NUM_ROWS-1:0]       row_lit,
  output logic [SPEED_W-1:0]        speed,
  output logic [SCORE_W-1:0]        score,
  output logic                      game_over,
  output logic                      busy
);

  state_e                 state, state_n;
  logic [ROW_IDX_W-1:0]   row_idx, row_idx_n;
  logic [ROW_IDX_W-1:0]   prev_idx;
  logic [POS_W-1:0]       locked   [NUM_ROWS];
  logic [POS_W-1:0]       locked_n [NUM_ROWS];
  logic [POS_W-1:0]       pos_arr  [NUM_ROWS];
  logic [NUM_ROWS-1:0]    run_n, lit_n;
  logic [SPEED_W-1:0]     speed_n;
  logic [SCORE_W-1:0]     score_n;
  logic                   game_over_n, busy_n;
  logic                   press;
  logic                   match;

  key_press_sync u_stop_key (
    .clk   (Clock),
    .rst_n (Resetn),
    .key_n (Stop),
    .press (press)
  );

  // Unpack the flat counter bus into per-row positions.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      pos_arr[r] = row_pos[r*POS_W +: POS_W];
    end
  end

  // The bottom row always matches; higher rows must land on the row below.
  always_comb begin
    prev_idx = row_idx - ROW_IDX_W'(1);
    match    = (row_idx == '0) || (locked[row_idx] == locked[prev_idx]);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      row_idx   <= '0;
      row_run   <= '0;
      row_lit   <= NUM_ROWS'(1);
      speed     <= SPEED_W'(1);
      score     <= '0;
      game_over <= 1'b0;
      busy      <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        locked[r] <= '0;
      end
    end else begin
      state     <= state_n;
      row_idx   <= row_idx_n;
      row_run   <= run_n;
      row_lit   <= lit_n;
      speed     <= speed_n;
      score     <= score_n;
      game_over <= game_over_n;
      busy      <= busy_n;
      locked    <= locked_n;
    end
  end

  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    run_n     = row_run;
    lit_n     = row_lit;
    speed_n   = speed;
    score_n   = score;
    locked_n  = locked;

    case (state)
      IDLE, OVER: begin
        run_n = '0;
        if (press) begin
          state_n   = PLAY;
          row_idx_n = '0;
          run_n     = NUM_ROWS'(1);
          lit_n     = NUM_ROWS'(1);
          score_n   = '0;
          speed_n   = SPEED_W'(1);
        end
      end
      PLAY: begin
        if (press) begin
          locked_n[row_idx] = pos_arr[row_idx];
          run_n             = '0;
          state_n           = CHECK;
        end
      end
      CHECK: begin
        if (!match) begin
          state_n = OVER;
        end else if (row_idx == ROW_IDX_W'(NUM_ROWS - 1)) begin
          state_n = LEVEL_UP;
        end else begin
          row_idx_n = row_idx + ROW_IDX_W'(1);
          run_n     = row_onehot(row_idx + ROW_IDX_W'(1));
          lit_n     = row_lit | row_onehot(row_idx + ROW_IDX_W'(1));
          state_n   = PLAY;
        end
      end
      LEVEL_UP: begin
        if (score != {SCORE_W{1'b1}}) begin
          score_n = score + SCORE_W'(1);
        end
        if (speed < SPEED_W'(MAX_LEVEL)) begin
          speed_n = speed + SPEED_W'(1);
        end
        row_idx_n = '0;
        run_n     = NUM_ROWS'(1);
        lit_n     = NUM_ROWS'(1);
        state_n   = PLAY;
      end
      default: begin
        state_n = IDLE;
        run_n   = '0;
      end
    endcase

    game_over_n = (state_n == OVER);
    busy_n      = (state_n == CHECK) || (state_n == LEVEL_UP);
  end

endmodule
